// File: rtl/player_move_ctrl.sv
// Player sprite position controller: debounced buttons move the player once per
// frame (vsync fall), and the new position is pushed to the sprite registers.
module player_move_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int STEP            = 2,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 624,
    parameter int Y_MIN           = 0,
    parameter int Y_MAX           = 464,
    parameter int X_INIT          = 32,
    parameter int Y_INIT          = 240
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        btn_up_n,
    input  logic        btn_down_n,
    input  logic        btn_left_n,
    input  logic        btn_right_n,
    input  logic        vsync_n,
    input  logic        respawn,
    output logic [1:0]  avm_address,
    output logic [31:0] avm_writedata,
    output logic        avm_write,
    input  logic        avm_waitrequest,
    output logic [9:0]  player_x,
    output logic [9:0]  player_y,
    output logic        busy,
    output logic [7:0]  missed_frames
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [9:0] STEP_P   = 10'(STEP);
    localparam logic [9:0] X_MIN_P  = 10'(X_MIN);
    localparam logic [9:0] X_MAX_P  = 10'(X_MAX);
    localparam logic [9:0] Y_MIN_P  = 10'(Y_MIN);
    localparam logic [9:0] Y_MAX_P  = 10'(Y_MAX);
    localparam logic [9:0] X_INIT_P = 10'(X_INIT);
    localparam logic [9:0] Y_INIT_P = 10'(Y_INIT);

    typedef enum logic [1:0] {IDLE, CALC, WR_X, WR_Y} state_t;

    state_t     state, state_next;
    logic [3:0] btn_raw, btn_s1, btn_s2, btn_db_n;
    logic       vs_s1, vs_s2, vs_prev, tick;
    logic       pending, respawn_flag;
    logic       press_up, press_down, press_left, press_right;
    logic [9:0] x_step, y_step;

    // Bit order: 0 = up, 1 = down, 2 = left, 3 = right (all active-low).
    assign btn_raw = {btn_right_n, btn_left_n, btn_down_n, btn_up_n};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, as the hardware does.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            btn_s1  <= '1;
            btn_s2  <= '1;
            vs_s1   <= 1'b1;
            vs_s2   <= 1'b1;
            vs_prev <= 1'b1;
        end else begin
            btn_s1  <= btn_raw;
            btn_s2  <= btn_s1;
            vs_s1   <= vsync_n;
            vs_s2   <= vs_s1;
            vs_prev <= vs_s2;
        end
    end

    assign tick = vs_prev & ~vs_s2;

    for (genvar i = 0; i < 4; i++) begin : g_debounce
        logic [CW-1:0] cnt;
        logic          db_n;

        // Any cycle where the synced input agrees with the accepted state restarts the count.
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                cnt  <= '0;
                db_n <= 1'b1;
            end else if (btn_s2[i] == db_n) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt  <= '0;
                db_n <= btn_s2[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign btn_db_n[i] = db_n;
    end

    assign press_up    = ~btn_db_n[0];
    assign press_down  = ~btn_db_n[1];
    assign press_left  = ~btn_db_n[2];
    assign press_right = ~btn_db_n[3];

    // Subtractions are only taken when they cannot go below the bound, so no wrap.
    function automatic logic [9:0] move_axis(input logic [9:0] pos, input logic dec,
                                             input logic inc, input logic [9:0] lo,
                                             input logic [9:0] hi);
        logic [9:0] r;
        r = pos;
        if (dec && !inc)
            r = (pos >= lo && (pos - lo) >= STEP_P) ? pos - STEP_P : lo;
        else if (inc && !dec)
            r = (hi >= pos && (hi - pos) >= STEP_P) ? pos + STEP_P : hi;
        return r;
    endfunction

    assign x_step = move_axis(player_x, press_left, press_right, X_MIN_P, X_MAX_P);
    assign y_step = move_axis(player_y, press_up, press_down, Y_MIN_P, Y_MAX_P);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        avm_write     = 1'b0;
        avm_address   = 2'd0;
        avm_writedata = 32'd0;
        case (state)
            IDLE: if (tick || pending) state_next = CALC;
            CALC: state_next = WR_X;
            WR_X: begin
                avm_write     = 1'b1;
                avm_writedata = {22'b0, player_x};
                if (!avm_waitrequest) state_next = WR_Y;
            end
            WR_Y: begin
                avm_write     = 1'b1;
                avm_address   = 2'd1;
                avm_writedata = {22'b0, player_y};
                if (!avm_waitrequest) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state         <= IDLE;
            pending       <= 1'b0;
            missed_frames <= 8'd0;
            respawn_flag  <= 1'b0;
            player_x      <= X_INIT_P;
            player_y      <= Y_INIT_P;
        end else begin
            state <= state_next;

            // IDLE either has nothing pending or is about to consume it in CALC.
            if (state == IDLE) begin
                pending <= 1'b0;
            end else if (tick) begin
                if (!pending)
                    pending <= 1'b1;
                else if (missed_frames != 8'hFF)
                    missed_frames <= missed_frames + 8'd1;
            end

            respawn_flag <= (state == CALC) ? 1'b0 : (respawn_flag | respawn);

            if (state == CALC) begin
                if (respawn_flag || respawn) begin
                    player_x <= X_INIT_P;
                    player_y <= Y_INIT_P;
                end else begin
                    player_x <= x_step;
                    player_y <= y_step;
                end
            end
        end
    end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Self-checking bench for player_move_ctrl: a frame-level position model and a
// write scoreboard, with a second instance placed near the lower X / upper Y bounds.
module tb_player_move_ctrl;

    localparam int DEB = 4;
    localparam int STEP = 2;
    localparam int XI = 32, YI = 240, OXI = 1, OYI = 463;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_up_n, btn_down_n, btn_left_n, btn_right_n;
    logic vsync_n, respawn, waitreq;

    logic [1:0]  avm_address, o_address;
    logic [31:0] avm_writedata, o_writedata;
    logic        avm_write, o_write, busy, o_busy;
    logic [9:0]  player_x, player_y, o_x, o_y;
    logic [7:0]  missed_frames, o_missed;

    player_move_ctrl #(.DEBOUNCE_CYCLES(DEB), .STEP(STEP)) u_dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
        .btn_left_n(btn_left_n), .btn_right_n(btn_right_n),
        .vsync_n(vsync_n), .respawn(respawn),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_write(avm_write), .avm_waitrequest(waitreq),
        .player_x(player_x), .player_y(player_y),
        .busy(busy), .missed_frames(missed_frames)
    );

    player_move_ctrl #(.DEBOUNCE_CYCLES(DEB), .STEP(STEP), .X_INIT(OXI), .Y_INIT(OYI)) u_dut_edge (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
        .btn_left_n(btn_left_n), .btn_right_n(btn_right_n),
        .vsync_n(vsync_n), .respawn(respawn),
        .avm_address(o_address), .avm_writedata(o_writedata),
        .avm_write(o_write), .avm_waitrequest(waitreq),
        .player_x(o_x), .player_y(o_y),
        .busy(o_busy), .missed_frames(o_missed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: positions of both instances, respawn request, held buttons.
    int mx, my, mox, moy;
    bit m_resp;
    bit p_up, p_down, p_left, p_right;
    logic [33:0] wr_q[$];

    // Accepted writes: write high and no stall just before the capturing edge.
    always @(negedge clk)
        if (rst_n && avm_write && !waitreq) wr_q.push_back({avm_address, avm_writedata});

    function automatic int clamp(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        mx = XI; my = YI; mox = OXI; moy = OYI; m_resp = 0;
    endtask

    task automatic model_frame();
        int dx, dy;
        if (m_resp) begin
            model_reset();
        end else begin
            dx = (p_right && !p_left) ? STEP : ((p_left && !p_right) ? -STEP : 0);
            dy = (p_down && !p_up) ? STEP : ((p_up && !p_down) ? -STEP : 0);
            mx  = clamp(mx + dx, 0, 624);  my  = clamp(my + dy, 0, 464);
            mox = clamp(mox + dx, 0, 624); moy = clamp(moy + dy, 0, 464);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_buttons(input bit u, input bit d, input bit l, input bit r);
        p_up = u; p_down = d; p_left = l; p_right = r;
        btn_up_n = ~u; btn_down_n = ~d; btn_left_n = ~l; btn_right_n = ~r;
        step(10);
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!busy && n < 12) begin step(); n++; end
        checks++;
        if (!busy) begin errors++; $display("FAIL %s start: busy never rose", name); end
    endtask

    task automatic wait_idle(input string name, input bit rnd);
        int n = 0;
        while (busy && n < 300) begin
            if (rnd) waitreq = 1'($urandom_range(0, 1));
            step(); n++;
        end
        waitreq = 1'b0;
        checks++;
        if (busy) begin errors++; $display("FAIL %s end: still busy after budget", name); end
    endtask

    // One complete frame update, checked against the model and the scoreboard.
    task automatic do_frame(input string name, input bit rnd);
        model_frame();
        wr_q.delete();
        vsync_n = 1'b0;
        wait_busy(name);
        vsync_n = 1'b1;
        wait_idle(name, rnd);
        @(negedge clk);
        checks += 5;
        if (player_x !== 10'(mx)) begin errors++; $display("FAIL %s x: got %0d exp %0d", name, player_x, mx); end
        if (player_y !== 10'(my)) begin errors++; $display("FAIL %s y: got %0d exp %0d", name, player_y, my); end
        if (o_x !== 10'(mox)) begin errors++; $display("FAIL %s edge x: got %0d exp %0d", name, o_x, mox); end
        if (o_y !== 10'(moy)) begin errors++; $display("FAIL %s edge y: got %0d exp %0d", name, o_y, moy); end
        if (wr_q.size() != 2 || wr_q[0] !== {2'd0, 32'(mx)} || wr_q[1] !== {2'd1, 32'(my)}) begin
            errors++;
            $display("FAIL %s writes: got %0d writes, first %h exp %h", name, wr_q.size(),
                     (wr_q.size() > 0) ? wr_q[0] : 34'h0, {2'd0, 32'(mx)});
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        btn_up_n = 1; btn_down_n = 1; btn_left_n = 1; btn_right_n = 1;
        p_up = 0; p_down = 0; p_left = 0; p_right = 0;
        vsync_n = 1; respawn = 0; waitreq = 0;
        #2 rst_n = 1'b0;
        step(3);
        @(negedge clk);
        checks += 4;
        if (avm_write !== 1'b0 || avm_address !== 2'd0 || avm_writedata !== 32'd0) begin
            errors++; $display("FAIL reset bus: got w%b a%0d d%0d exp w0 a0 d0", avm_write, avm_address, avm_writedata);
        end
        if (player_x !== 10'(XI) || player_y !== 10'(YI)) begin
            errors++; $display("FAIL reset pos: got (%0d,%0d) exp (%0d,%0d)", player_x, player_y, XI, YI);
        end
        if (busy !== 1'b0 || missed_frames !== 8'd0) begin
            errors++; $display("FAIL reset status: got busy %b missed %0d exp 0 0", busy, missed_frames);
        end
        if (o_x !== 10'(OXI) || o_y !== 10'(OYI)) begin
            errors++; $display("FAIL reset edge pos: got (%0d,%0d) exp (%0d,%0d)", o_x, o_y, OXI, OYI);
        end
        step();
        rst_n = 1'b1;
        model_reset();
        step(2);
    endtask

    // Right held, one vsync fall, no wait states: cycle-by-cycle bus sequence.
    task automatic test_latency();
        set_buttons(0, 0, 0, 1);
        model_frame();
        wr_q.delete();
        vsync_n = 1'b0;
        wait_busy("latency");
        checks++;
        if (avm_write !== 1'b0) begin errors++; $display("FAIL latency calc: got write %b exp 0", avm_write); end
        step();
        checks++;
        if (avm_write !== 1'b1 || avm_address !== 2'd0 || avm_writedata !== 32'd34) begin
            errors++; $display("FAIL latency wr_x: got w%b a%0d d%0d exp w1 a0 d34", avm_write, avm_address, avm_writedata);
        end
        step();
        checks++;
        if (avm_write !== 1'b1 || avm_address !== 2'd1 || avm_writedata !== 32'd240) begin
            errors++; $display("FAIL latency wr_y: got w%b a%0d d%0d exp w1 a1 d240", avm_write, avm_address, avm_writedata);
        end
        step();
        vsync_n = 1'b1;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL latency idle: got busy %b exp 0", busy); end
        if (wr_q.size() != 2 || player_x !== 10'd34) begin
            errors++; $display("FAIL latency result: got %0d writes x %0d exp 2 writes x 34", wr_q.size(), player_x);
        end
        step(2);
    endtask

    task automatic test_clamp();
        set_buttons(0, 1, 1, 0);
        do_frame("clamp_first", 0);
        do_frame("clamp_hold", 0);
    endtask

    task automatic test_stall();
        set_buttons(0, 0, 0, 1);
        model_frame();
        wr_q.delete();
        waitreq = 1'b1;
        vsync_n = 1'b0;
        wait_busy("stall");
        vsync_n = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (avm_write !== 1'b1 || avm_address !== 2'd0 || avm_writedata !== 32'(mx)) begin
                errors++;
                $display("FAIL stall hold %0d: got w%b a%0d d%0d exp w1 a0 d%0d", i, avm_write, avm_address, avm_writedata, mx);
            end
            step();
        end
        waitreq = 1'b0;
        wait_idle("stall", 0);
        checks++;
        if (wr_q.size() != 2 || wr_q[0] !== {2'd0, 32'(mx)} || wr_q[1] !== {2'd1, 32'(my)}) begin
            errors++; $display("FAIL stall writes: got %0d writes exp 2", wr_q.size());
        end
        step();
    endtask

    task automatic test_missed();
        int fx;
        set_buttons(0, 0, 1, 0);
        model_frame();
        fx = mx;
        model_frame();
        wr_q.delete();
        waitreq = 1'b1;
        vsync_n = 1'b0;
        wait_busy("missed");
        vsync_n = 1'b1;
        step(4);
        repeat (3) begin vsync_n = 1'b0; step(4); vsync_n = 1'b1; step(4); end
        checks += 2;
        if (missed_frames !== 8'd2) begin errors++; $display("FAIL missed count: got %0d exp 2", missed_frames); end
        if (avm_write !== 1'b1 || avm_address !== 2'd0) begin
            errors++; $display("FAIL missed stalled: got w%b a%0d exp w1 a0", avm_write, avm_address);
        end
        waitreq = 1'b0;
        step(14);
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL missed idle: got busy %b exp 0", busy); end
        if (wr_q.size() != 4 || wr_q[0] !== {2'd0, 32'(fx)} || wr_q[2] !== {2'd0, 32'(mx)}) begin
            errors++; $display("FAIL missed writes: got %0d writes exp 4", wr_q.size());
        end
        if (player_x !== 10'(mx) || player_y !== 10'(my)) begin
            errors++; $display("FAIL missed pos: got (%0d,%0d) exp (%0d,%0d)", player_x, player_y, mx, my);
        end
    endtask

    task automatic test_glitch();
        set_buttons(0, 0, 0, 0);
        btn_left_n = 1'b0;
        step(3);
        btn_left_n = 1'b1;
        step(10);
        do_frame("glitch", 0);
    endtask

    task automatic test_respawn();
        set_buttons(0, 0, 0, 1);
        model_frame();
        wr_q.delete();
        waitreq = 1'b1;
        vsync_n = 1'b0;
        wait_busy("respawn");
        vsync_n = 1'b1;
        step();
        waitreq = 1'b0;
        step();
        waitreq = 1'b1;
        respawn = 1'b1;
        checks++;
        if (avm_write !== 1'b1 || avm_address !== 2'd1) begin
            errors++; $display("FAIL respawn in wr_y: got w%b a%0d exp w1 a1", avm_write, avm_address);
        end
        step();
        respawn = 1'b0;
        m_resp = 1;
        waitreq = 1'b0;
        wait_idle("respawn", 0);
        checks++;
        if (player_x !== 10'(mx)) begin errors++; $display("FAIL respawn pre: got x %0d exp %0d", player_x, mx); end
        step();
        do_frame("respawn_apply", 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            set_buttons(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                respawn = 1'b1; step(); respawn = 1'b0; m_resp = 1;
            end
            do_frame("random", 1);
        end
    endtask

    task automatic test_saturate();
        set_buttons(0, 0, 0, 0);
        model_frame();
        model_frame();
        waitreq = 1'b1;
        vsync_n = 1'b0;
        wait_busy("saturate");
        vsync_n = 1'b1;
        step(3);
        repeat (260) begin vsync_n = 1'b0; step(3); vsync_n = 1'b1; step(3); end
        checks++;
        if (missed_frames !== 8'd255) begin errors++; $display("FAIL saturate: got %0d exp 255", missed_frames); end
        waitreq = 1'b0;
        step(14);
        checks++;
        if (busy !== 1'b0 || player_x !== 10'(mx)) begin
            errors++; $display("FAIL saturate drain: got busy %b x %0d exp 0 %0d", busy, player_x, mx);
        end
    endtask

    task automatic test_reset_mid();
        set_buttons(0, 0, 0, 1);
        waitreq = 1'b1;
        vsync_n = 1'b0;
        wait_busy("reset_mid");
        vsync_n = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (avm_write !== 1'b1) begin errors++; $display("FAIL reset_mid pre: got write %b exp 1", avm_write); end
        #1 rst_n = 1'b0;
        #1;
        checks += 3;
        if (avm_write !== 1'b0 || avm_address !== 2'd0 || avm_writedata !== 32'd0) begin
            errors++; $display("FAIL reset_mid bus: got w%b a%0d d%0d exp w0 a0 d0", avm_write, avm_address, avm_writedata);
        end
        if (player_x !== 10'(XI) || player_y !== 10'(YI)) begin
            errors++; $display("FAIL reset_mid pos: got (%0d,%0d) exp (%0d,%0d)", player_x, player_y, XI, YI);
        end
        if (busy !== 1'b0 || missed_frames !== 8'd0) begin
            errors++; $display("FAIL reset_mid status: got busy %b missed %0d exp 0 0", busy, missed_frames);
        end
        model_reset();
        wr_q.delete();
        step(2);
        rst_n = 1'b1;
        waitreq = 1'b0;
        step(12);
        checks++;
        if (busy !== 1'b0 || wr_q.size() != 0) begin
            errors++; $display("FAIL reset_mid after: got busy %b writes %0d exp 0 0", busy, wr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_clamp();
        test_stall();
        test_missed();
        test_glitch();
        test_respawn();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
